// File: rtl/tile_text_engine.sv
`default_nettype none
// ============================================================================
// Module   : tile_text_engine
// Brief    : Parametrised character-cell text display engine. COLS x ROWS
//            attribute/character RAM with host write port, auto-clear
//            sequencer and a 2-stage pixel pipeline between the sync
//            generator and the VGA pins. Glyph ROM is external.
//            Optional blinking cursor: define TILE_TEXT_CURSOR_EN.
// Revision : 1.0 - initial release
// ============================================================================
module tile_text_engine #(
   parameter int          COLS         = 32,
   parameter int          ROWS         = 30,
   parameter int          CW_BITS      = 3,
   parameter int          CH_BITS      = 3,
   parameter int          POS_W        = 9,
   parameter int          GLYPH_W      = 5,
`ifdef TILE_TEXT_CURSOR_EN
   parameter int          BLINK_FRAMES = 32,
`endif
   parameter logic [7:0]  CLR_VALUE    = 8'h00
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [POS_W-1:0]   hpos,
   input  logic [POS_W-1:0]   vpos,
   input  logic               display_on,
   input  logic               hsync_in,
   input  logic               vsync_in,
   input  logic [11:0]        host_addr,
   input  logic [7:0]         host_data,
   input  logic               host_we,
   output logic               host_ready,
   input  logic               clr_req,
   output logic               busy,
`ifdef TILE_TEXT_CURSOR_EN
   input  logic [5:0]         cursor_col,
   input  logic [5:0]         cursor_row,
`endif
   output logic [3:0]         glyph_code,
   output logic [CH_BITS-1:0] glyph_row,
   input  logic [GLYPH_W-1:0] glyph_bits,
   output logic               hsync,
   output logic               vsync,
   output logic [2:0]         rgb
);

   localparam int              DEPTH     = COLS * ROWS;
   localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [12:0]     DEPTH_W   = 13'(DEPTH);
   localparam logic [AW-1:0]   LAST_ADDR = AW'(DEPTH - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_IDLE  = 1'b1
   } state_t;

   // ---------------------------------------------------------------------
   // Declarations
   // ---------------------------------------------------------------------
   state_t               state_q;
   logic [AW-1:0]        caddr_q;
   logic                 busy_q;
   logic                 ready_q;

   logic [7:0]           mem_q [DEPTH];
   logic [7:0]           rd_q;

   logic [POS_W-1:0]     w_row;
   logic [POS_W-1:0]     w_col;
   logic                 w_oob;
   logic [AW-1:0]        w_rd_addr;

   logic                 w_host_ok;
   logic                 w_wr_en;
   logic [AW-1:0]        w_wr_addr;
   logic [7:0]           w_wr_data;

   logic [CW_BITS-1:0]   xofs_q;
   logic [CH_BITS-1:0]   yofs_q;
   logic                 de_q;
   logic                 oob_q;
   logic                 hs1_q;
   logic                 vs1_q;

   logic [GLYPH_W-1:0]   w_glyph_sh;
   logic                 w_cursor_hit;
   logic                 w_pix;

   logic [2:0]           rgb_q;
   logic                 hsync_q;
   logic                 vsync_q;

   // ---------------------------------------------------------------------
   // Stage 0 address generation; out-of-range cells read address 0 so the
   // RAM index never leaves the array, the oob flag blanks the pixel later.
   // ---------------------------------------------------------------------
   assign w_row     = vpos >> CH_BITS;
   assign w_col     = hpos >> CW_BITS;
   assign w_oob     = (32'(w_row) >= ROWS) || (32'(w_col) >= COLS);
   assign w_rd_addr = w_oob ? '0 : AW'(32'(w_row) * COLS + 32'(w_col));

   // Host writes land only while idle and only inside the array (no wrap).
   assign w_host_ok = host_we && ready_q && ({1'b0, host_addr} < DEPTH_W);
   assign w_wr_en   = (state_q == ST_CLEAR) || w_host_ok;
   assign w_wr_addr = (state_q == ST_CLEAR) ? caddr_q : AW'(host_addr);
   assign w_wr_data = (state_q == ST_CLEAR) ? CLR_VALUE : host_data;

   // Clear sequencer: sweeps the whole RAM after reset or on request.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_CLEAR;
         caddr_q <= '0;
         busy_q  <= 1'b1;
         ready_q <= 1'b0;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (caddr_q == LAST_ADDR) begin
                  state_q <= ST_IDLE;
                  caddr_q <= '0;
                  busy_q  <= 1'b0;
                  ready_q <= 1'b1;
               end else begin
                  caddr_q <= caddr_q + 1'b1;
               end
            end
            ST_IDLE: begin
               if (clr_req) begin
                  state_q <= ST_CLEAR;
                  caddr_q <= '0;
                  busy_q  <= 1'b1;
                  ready_q <= 1'b0;
               end
            end
            default: begin
               state_q <= ST_CLEAR;
               caddr_q <= '0;
               busy_q  <= 1'b1;
               ready_q <= 1'b0;
            end
         endcase
      end
   end

   // Character RAM write port; contents are deliberately not reset.
   always_ff @(posedge clk) begin
      if (w_wr_en) begin
         mem_q[w_wr_addr] <= w_wr_data;
      end
   end

   // Display read port: read-before-write, so a same-address write is not seen.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_q <= 8'h00;
      end else begin
         rd_q <= mem_q[w_rd_addr];
      end
   end

   // Stage 0 -> 1 registers carrying the cell offsets and sync/enable flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         xofs_q <= '0;
         yofs_q <= '0;
         de_q   <= 1'b0;
         oob_q  <= 1'b0;
         hs1_q  <= 1'b0;
         vs1_q  <= 1'b0;
      end else begin
         xofs_q <= hpos[CW_BITS-1:0];
         yofs_q <= vpos[CH_BITS-1:0];
         de_q   <= display_on;
         oob_q  <= w_oob;
         hs1_q  <= hsync_in;
         vs1_q  <= vsync_in;
      end
   end

`ifdef TILE_TEXT_CURSOR_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

   logic [POS_W-1:0] ccol_q;
   logic [POS_W-1:0] crow_q;
   logic             vs_prev_q;
   logic [BW-1:0]    frame_q;
   logic             phase_q;

   // Cell coordinates of the stage-1 pixel, for the cursor match.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ccol_q <= '0;
         crow_q <= '0;
      end else begin
         ccol_q <= w_col;
         crow_q <= w_row;
      end
   end

   // Blink timer: counts vsync rising edges, flips phase every BLINK_FRAMES.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vs_prev_q <= 1'b0;
         frame_q   <= '0;
         phase_q   <= 1'b0;
      end else begin
         vs_prev_q <= vsync_in;
         if (vsync_in && !vs_prev_q) begin
            if (frame_q == BW'(BLINK_FRAMES - 1)) begin
               frame_q <= '0;
               phase_q <= ~phase_q;
            end else begin
               frame_q <= frame_q + 1'b1;
            end
         end
      end
   end

   assign w_cursor_hit = phase_q && (ccol_q == POS_W'(cursor_col)) &&
                         (crow_q == POS_W'(cursor_row));
`else
   assign w_cursor_hit = 1'b0;
`endif

   // Stage 1: shifting left by xofs brings glyph bit GLYPH_W-1-xofs to the
   // MSB; offsets past the glyph width shift everything out (blank column).
   assign w_glyph_sh = glyph_bits << xofs_q;
   assign w_pix      = w_glyph_sh[GLYPH_W-1] ^ rd_q[7] ^ w_cursor_hit;

   // Stage 2: registered colour and matching sync delay.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rgb_q   <= 3'b000;
         hsync_q <= 1'b0;
         vsync_q <= 1'b0;
      end else begin
         rgb_q   <= (de_q && !oob_q && w_pix) ? rd_q[6:4] : 3'b000;
         hsync_q <= hs1_q;
         vsync_q <= vs1_q;
      end
   end

   assign host_ready = ready_q;
   assign busy       = busy_q;
   assign glyph_code = rd_q[3:0];
   assign glyph_row  = yofs_q;
   assign rgb        = rgb_q;
   assign hsync      = hsync_q;
   assign vsync      = vsync_q;

endmodule
`default_nettype wire

// File: tb/tb_tile_text_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_tile_text_engine
// Brief    : Self-checking bench for tile_text_engine (default build) with
//            a behavioural screen/clear model and a synthetic glyph ROM.
// Revision : 1.0 - initial release
// ============================================================================
module tb_tile_text_engine;

   localparam int COLS    = 32;
   localparam int ROWS    = 30;
   localparam int DEPTH   = COLS * ROWS;
   localparam int GLYPH_W = 5;

   logic        clk = 1'b0;
   logic        reset;
   logic [8:0]  hpos, vpos;
   logic        display_on, hsync_in, vsync_in;
   logic [11:0] host_addr;
   logic [7:0]  host_data;
   logic        host_we, host_ready, clr_req, busy;
   logic [3:0]  glyph_code;
   logic [2:0]  glyph_row;
   logic [4:0]  glyph_bits;
   logic        hsync, vsync;
   logic [2:0]  rgb;

   tile_text_engine dut (
      .clk        (clk),
      .reset      (reset),
      .hpos       (hpos),
      .vpos       (vpos),
      .display_on (display_on),
      .hsync_in   (hsync_in),
      .vsync_in   (vsync_in),
      .host_addr  (host_addr),
      .host_data  (host_data),
      .host_we    (host_we),
      .host_ready (host_ready),
      .clr_req    (clr_req),
      .busy       (busy),
      .glyph_code (glyph_code),
      .glyph_row  (glyph_row),
      .glyph_bits (glyph_bits),
      .hsync      (hsync),
      .vsync      (vsync),
      .rgb        (rgb)
   );

   always #5 clk = ~clk;

   // Synthetic glyph ROM, different pattern per code and scanline.
   function automatic logic [4:0] rom(input logic [3:0] c, input logic [2:0] r);
      int v;
      v = (int'(c) * 9 + int'(r) * 5 + 7) ^ (int'(r) << 2);
      return v[4:0];
   endfunction

   always_comb glyph_bits = rom(glyph_code, glyph_row);

   // Reference model state.
   typedef struct {
      logic [2:0] rgb;
      logic       hs;
      logic       vs;
   } exp_t;

   logic [7:0] mem [DEPTH];
   int         clear_left;
   exp_t       q[$];
   int         n_vec  = 0;
   int         n_fail = 0;

   // Colour of one beam position as the screen contents dictate.
   function automatic logic [2:0] ref_pixel(input int h, input int v, input logic de);
      logic [7:0] w;
      int g, x, p;
      if (!de || (v / 8) >= ROWS || (h / 8) >= COLS) return 3'b000;
      w = mem[(v / 8) * COLS + (h / 8)];
      g = int'(rom(w[3:0], 3'(v % 8)));
      x = h % 8;
      p = (x < GLYPH_W) ? ((g >> (GLYPH_W - 1 - x)) & 1) : 0;
      if (w[7]) p = 1 - p;
      return (p != 0) ? w[6:4] : 3'b000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: predict output for current inputs, advance model, compare.
   task automatic step();
      exp_t e;
      e.rgb = ref_pixel(int'(hpos), int'(vpos), display_on);
      e.hs  = hsync_in;
      e.vs  = vsync_in;
      q.push_back(e);
      @(posedge clk);
      if (clear_left > 0) begin
         mem[DEPTH - clear_left] = 8'h00;
         clear_left--;
      end else begin
         if (host_we && int'(host_addr) < DEPTH) mem[host_addr] = host_data;
         if (clr_req) clear_left = DEPTH;
      end
      #1;
      chk("busy", 32'(busy), 32'(clear_left > 0));
      chk("host_ready", 32'(host_ready), 32'(clear_left == 0));
      if (q.size() >= 2) begin
         chk("rgb", 32'(rgb), 32'(q[0].rgb));
         chk("hsync", 32'(hsync), 32'(q[0].hs));
         chk("vsync", 32'(vsync), 32'(q[0].vs));
         void'(q.pop_front());
      end
   endtask

   task automatic rand_pix(input bit de_en);
      hpos       = 9'($urandom_range(0, 319));
      vpos       = 9'($urandom_range(0, 259));
      display_on = de_en ? ($urandom_range(0, 7) != 0) : 1'b0;
      hsync_in   = 1'($urandom_range(0, 1));
      vsync_in   = 1'($urandom_range(0, 1));
   endtask

   // Asynchronous reset: outputs must drop without waiting for a clock edge.
   task automatic do_reset();
      exp_t z;
      #2;
      reset = 1'b1;
      #1;
      chk("rst_busy", 32'(busy), 32'd1);
      chk("rst_ready", 32'(host_ready), 32'd0);
      chk("rst_rgb", 32'(rgb), 32'd0);
      chk("rst_hsync", 32'(hsync), 32'd0);
      chk("rst_vsync", 32'(vsync), 32'd0);
      repeat (2) @(posedge clk);
      #1;
      reset      = 1'b0;
      clear_left = DEPTH;
      q.delete();
      z.rgb = 3'b000;
      z.hs  = 1'b0;
      z.vs  = 1'b0;
      q.push_back(z);
   endtask

   task automatic count_busy(input string tag, input int clr_at);
      int cnt;
      cnt = 0;
      while (busy && cnt < 2000) begin
         rand_pix(1'b0);
         host_we   = 1'($urandom_range(0, 1));
         host_addr = 12'($urandom_range(0, DEPTH - 1));
         host_data = 8'($urandom_range(1, 255));
         clr_req   = (cnt == clr_at);
         step();
         cnt++;
      end
      host_we = 1'b0;
      clr_req = 1'b0;
      chk(tag, 32'(cnt), 32'(DEPTH));
   endtask

   task automatic scan_cell(input int h0, input int v0, input logic de);
      for (int y = 0; y < 8; y++) begin
         for (int x = 0; x < 8; x++) begin
            hpos       = 9'(h0 + x);
            vpos       = 9'(v0 + y);
            display_on = de;
            hsync_in   = 1'($urandom_range(0, 1));
            vsync_in   = 1'($urandom_range(0, 1));
            step();
         end
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = 8'h00;
      reset = 1'b1; hpos = '0; vpos = '0; display_on = 1'b0;
      hsync_in = 1'b0; vsync_in = 1'b0; host_addr = '0; host_data = '0;
      host_we = 1'b0; clr_req = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      do_reset();

      // Partial clear, then reset mid-clear: sequencer must restart at 0.
      for (int i = 0; i < 300; i++) begin
         rand_pix(1'b0);
         host_we   = 1'($urandom_range(0, 1));
         host_addr = 12'($urandom_range(0, DEPTH - 1));
         host_data = 8'($urandom_range(1, 255));
         step();
      end
      host_we = 1'b0;
      do_reset();
      count_busy("busy_len_reset", 400);

      // Directed cell: row 1 col 1, green char 1, then inverted.
      rand_pix(1'b1);
      host_we = 1'b1; host_addr = 12'd33; host_data = 8'h21;
      step();
      host_we = 1'b0;
      scan_cell(8, 8, 1'b1);
      host_we = 1'b1; host_addr = 12'd33; host_data = 8'hA1;
      step();
      host_we = 1'b0;
      scan_cell(8, 8, 1'b1);

      // Randomised traffic: pixels, host writes (incl. beyond DEPTH), rare clears.
      for (int i = 0; i < 2500; i++) begin
         rand_pix(1'b1);
         host_we   = ($urandom_range(0, 9) < 4);
         host_addr = 12'($urandom_range(0, 1100));
         host_data = 8'($urandom_range(0, 255));
         clr_req   = ($urandom_range(0, 999) == 0);
         step();
      end
      host_we = 1'b0;
      clr_req = 1'b0;

      // Wait for any clear to finish, then fill RAM with nonzero words.
      for (int i = 0; i < 2000 && busy; i++) begin
         rand_pix(1'b1);
         step();
      end
      for (int a = 0; a < DEPTH; a++) begin
         rand_pix(1'b1);
         host_we = 1'b1; host_addr = 12'(a); host_data = 8'(8'hF0 | 8'(a));
         step();
      end
      host_we = 1'b0;

      // Out-of-range column, out-of-range row, and display disabled.
      scan_cell(256, 8, 1'b1);
      scan_cell(8, 240, 1'b1);
      scan_cell(16, 16, 1'b0);
      scan_cell(16, 16, 1'b1);

      // Same-cycle write and clear request; write commits, then is cleared.
      rand_pix(1'b1);
      host_we = 1'b1; host_addr = 12'd5; host_data = 8'h13; clr_req = 1'b1;
      step();
      host_we = 1'b0; clr_req = 1'b0;
      count_busy("busy_len_clr", 500);
      scan_cell(40, 0, 1'b1);

      repeat (4) begin
         rand_pix(1'b1);
         step();
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
